// File: rtl/control_alu_secuencial.sv
// rtl/control_alu_secuencial.sv - handshake sequencer for the 10-op ALU with iterative restoring divider
module control_alu_secuencial #(
  parameter int ANCHO = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [ANCHO:0] operandoA,
  input  logic [ANCHO:0] operandoB,
  input  logic [3:0]     opcode,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [ANCHO:0] resultado,
  output logic           flag_N,
  output logic           flag_Z,
  output logic           flag_C,
  output logic           flag_V,
  output logic           error,
  output logic           ocupado
);

  localparam int W  = ANCHO + 1;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  res_q, res_d;
  logic          n_q, n_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          v_q, v_d;
  logic          err_q, err_d;

  logic [W-1:0]  exec_res;
  logic          exec_c;
  logic          exec_v;
  logic          exec_err;
  logic [W:0]    sum_w;
  logic [W-1:0]  diff_w;
  logic [2*W-1:0] prod_w;
  logic          shift_big;

  logic [W:0]    r_sh;
  logic          r_ge;
  logic [W-1:0]  r_next;
  logic [W-1:0]  q_next;
  logic [W-1:0]  div_fin;

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign ocupado   = (state_q != ST_IDLE);
  assign resultado = res_q;
  assign flag_N    = n_q;
  assign flag_Z    = z_q;
  assign flag_C    = c_q;
  assign flag_V    = v_q;
  assign error     = err_q;

  // Single-cycle datapath on the latched operands; div/mod only reach here with B == 0
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    diff_w    = a_q - b_q;
    prod_w    = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    shift_big = ({{(32-W){1'b0}}, b_q} >= W);
    exec_res  = '0;
    exec_c    = 1'b0;
    exec_v    = 1'b0;
    exec_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = sum_w[W-1:0];
        exec_c   = sum_w[W];
        exec_v   = (a_q[ANCHO] == b_q[ANCHO]) && (sum_w[ANCHO] != a_q[ANCHO]);
      end
      OP_SUB: begin
        exec_res = diff_w;
        exec_c   = (a_q < b_q);
        exec_v   = (a_q[ANCHO] != b_q[ANCHO]) && (diff_w[ANCHO] != a_q[ANCHO]);
      end
      OP_MUL: begin
        exec_res = prod_w[W-1:0];
        exec_c   = |prod_w[2*W-1:W];
      end
      OP_DIV: begin
        exec_res = '1;
        exec_err = 1'b1;
      end
      OP_MOD: begin
        exec_res = a_q;
        exec_err = 1'b1;
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SHL: exec_res = shift_big ? '0 : (a_q << b_q);
      OP_SHR: exec_res = shift_big ? '0 : (a_q >> b_q);
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract B when it fits
  always_comb begin
    r_sh    = {rem_q, quot_q[W-1]};
    r_ge    = (r_sh >= {1'b0, b_q});
    r_next  = r_ge ? (r_sh[W-1:0] - b_q) : r_sh[W-1:0];
    q_next  = {quot_q[W-2:0], r_ge};
    div_fin = (op_q == OP_DIV) ? q_next : r_next;
  end

  // Next-state logic for the controller FSM and its result registers
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    res_d   = res_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d  = operandoA;
          b_d  = operandoB;
          op_d = opcode;
          if (((opcode == OP_DIV) || (opcode == OP_MOD)) && (operandoB != '0)) begin
            state_d = ST_DIV;
            cnt_d   = CW'(W);
            rem_d   = '0;
            quot_d  = operandoA;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d   = exec_res;
        n_d     = exec_res[ANCHO];
        z_d     = (exec_res == '0);
        c_d     = exec_c;
        v_d     = exec_v;
        err_d   = exec_err;
        state_d = ST_DONE;
      end
      ST_DIV: begin
        rem_d  = r_next;
        quot_d = q_next;
        cnt_d  = cnt_q - CW'(1);
        // The last step writes the result directly so DONE lands W edges after acceptance
        if (cnt_q == CW'(1)) begin
          res_d   = div_fin;
          n_d     = div_fin[ANCHO];
          z_d     = (div_fin == '0);
          c_d     = 1'b0;
          v_d     = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_control_alu_secuencial.sv
// tb/tb_control_alu_secuencial.sv - directed self-checking bench for control_alu_secuencial
module tb_control_alu_secuencial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] operandoA;
  logic [3:0] operandoB;
  logic [3:0] opcode;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] resultado;
  logic       flag_N;
  logic       flag_Z;
  logic       flag_C;
  logic       flag_V;
  logic       error;
  logic       ocupado;

  int checks;
  int errors;

  control_alu_secuencial #(.ANCHO(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .operandoA(operandoA),
    .operandoB(operandoB),
    .opcode(opcode),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .resultado(resultado),
    .flag_N(flag_N),
    .flag_Z(flag_Z),
    .flag_C(flag_C),
    .flag_V(flag_V),
    .error(error),
    .ocupado(ocupado)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    @(negedge clk);
    operandoA = a;
    operandoB = b;
    opcode    = op;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, res_valid, ocupado, resultado, flag_N, flag_Z, flag_C, flag_V, error} !== 12'b1_0_0_0000_0_0_0_0_0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b oc=%b res=%0d NZCV=%b%b%b%b err=%b, expected rdy=1 others 0",
               in_ready, res_valid, ocupado, resultado, flag_N, flag_Z, flag_C, flag_V, error);
    end
    @(negedge clk);
    rst = 1'b0;

    accept(4'd9, 4'd2, 4'b0011);
    step();
    step();
    checks++;
    if (ocupado !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_div_busy: got oc=%b rv=%b, expected oc=1 rv=0", ocupado, res_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || resultado !== 4'd0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: got rdy=%b rv=%b res=%0d oc=%b, expected rdy=1 rv=0 res=0 oc=0",
               in_ready, res_valid, resultado, ocupado);
    end
    @(negedge clk);
    rst = 1'b0;

    accept(4'd9, 4'd2, 4'b0011);
    repeat (3) step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_after_reset_early: got rv=%b, expected 0", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd4 || error !== 1'b0) begin
      errors++;
      $display("FAIL div_after_reset: got rv=%b res=%0d err=%b, expected rv=1 res=4 err=0", res_valid, resultado, error);
    end
    consume();
  endtask

  task automatic test_add_sub();
    accept(4'd7, 4'd9, 4'b0000);
    step();
    checks++;
    if ({res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error} !== 10'b1_0000_0_1_1_0_0) begin
      errors++;
      $display("FAIL add_7_9: got rv=%b res=%0d NZCV=%b%b%b%b err=%b, expected rv=1 res=0 NZCV=0110 err=0",
               res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error);
    end
    consume();

    accept(4'd3, 4'd5, 4'b0001);
    step();
    checks++;
    if ({res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error} !== 10'b1_1110_1_0_1_0_0) begin
      errors++;
      $display("FAIL sub_3_5: got rv=%b res=%0d NZCV=%b%b%b%b err=%b, expected rv=1 res=14 NZCV=1010 err=0",
               res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error);
    end
    consume();

    accept(4'd5, 4'd3, 4'b0000);
    step();
    checks++;
    if ({resultado, flag_N, flag_Z, flag_C, flag_V} !== 8'b1000_1_0_0_1) begin
      errors++;
      $display("FAIL add_5_3_overflow: got res=%0d NZCV=%b%b%b%b, expected res=8 NZCV=1001",
               resultado, flag_N, flag_Z, flag_C, flag_V);
    end
    consume();
  endtask

  task automatic test_div_mod();
    accept(4'd13, 4'd4, 4'b0011);
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (res_valid !== 1'b0 || ocupado !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL div_busy_cycle%0d: got rv=%b oc=%b rdy=%b, expected rv=0 oc=1 rdy=0", i, res_valid, ocupado, in_ready);
      end
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || ocupado !== 1'b1 || resultado !== 4'd3 || error !== 1'b0 || flag_Z !== 1'b0) begin
      errors++;
      $display("FAIL div_13_4: got rv=%b oc=%b res=%0d err=%b Z=%b, expected rv=1 oc=1 res=3 err=0 Z=0",
               res_valid, ocupado, resultado, error, flag_Z);
    end
    consume();

    accept(4'd13, 4'd4, 4'b0100);
    repeat (3) step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mod_early: got rv=%b, expected 0", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd1 || error !== 1'b0) begin
      errors++;
      $display("FAIL mod_13_4: got rv=%b res=%0d err=%b, expected rv=1 res=1 err=0", res_valid, resultado, error);
    end
    consume();
  endtask

  task automatic test_errors();
    accept(4'd5, 4'd0, 4'b0011);
    step();
    checks++;
    if ({res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error} !== 10'b1_1111_1_0_0_0_1) begin
      errors++;
      $display("FAIL div_by_zero: got rv=%b res=%0d NZCV=%b%b%b%b err=%b, expected rv=1 res=15 NZCV=1000 err=1",
               res_valid, resultado, flag_N, flag_Z, flag_C, flag_V, error);
    end
    consume();

    accept(4'd6, 4'd0, 4'b0100);
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd6 || error !== 1'b1) begin
      errors++;
      $display("FAIL mod_by_zero: got rv=%b res=%0d err=%b, expected rv=1 res=6 err=1", res_valid, resultado, error);
    end
    consume();

    accept(4'd7, 4'd3, 4'b1100);
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd0 || flag_Z !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got rv=%b res=%0d Z=%b err=%b, expected rv=1 res=0 Z=1 err=1",
               res_valid, resultado, flag_Z, error);
    end
    consume();
  endtask

  task automatic test_backpressure();
    accept(4'd5, 4'd4, 4'b0010);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = (i % 2 == 0);
      operandoA = 4'd1;
      operandoB = 4'd1;
      opcode    = 4'b0000;
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || resultado !== 4'd4 || flag_C !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_hold_cycle%0d: got rv=%b res=%0d C=%b rdy=%b, expected rv=1 res=4 C=1 rdy=0",
                 i, res_valid, resultado, flag_C, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_release: got rdy=%b rv=%b, expected rdy=1 rv=0", in_ready, res_valid);
    end

    accept(4'd12, 4'd10, 4'b0101);
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd8) begin
      errors++;
      $display("FAIL and_after_hold: got rv=%b res=%0d, expected rv=1 res=8", res_valid, resultado);
    end
    consume();

    accept(4'd12, 4'd10, 4'b0111);
    step();
    checks++;
    if (resultado !== 4'd6 || flag_C !== 1'b0) begin
      errors++;
      $display("FAIL xor_12_10: got res=%0d C=%b, expected res=6 C=0", resultado, flag_C);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    res_ready = 1'b1;
    accept(4'd3, 4'd1, 4'b1000);
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd6 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL shl_3_1: got rv=%b res=%0d rdy=%b, expected rv=1 res=6 rdy=0", res_valid, resultado, in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got rdy=%b rv=%b, expected rdy=1 rv=0", in_ready, res_valid);
    end
    accept(4'd8, 4'd5, 4'b1001);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL shr_accepted: got rdy=%b, expected 0", in_ready);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || resultado !== 4'd0 || flag_Z !== 1'b1) begin
      errors++;
      $display("FAIL shr_8_5: got rv=%b res=%0d Z=%b, expected rv=1 res=0 Z=1", res_valid, resultado, flag_Z);
    end
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    operandoA = '0;
    operandoB = '0;
    opcode    = '0;
    test_reset();
    test_add_sub();
    test_div_mod();
    test_errors();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
